al422_fifo_bam_driver: RTL and testbench

- Streams pre-formatted bitplane bytes out of an AL422 video FIFO and drives a HUB75-style RGB LED panel with binary angle modulation (BAM).
- The panel has two halves (rgb1 upper, rgb2 lower) and 1/32 scan.
- Sits between the AL422 read port and the panel connector.
- Owns the FIFO read-enable and read-pointer-reset signals, so the frame order is fully determined by this block.

---
 rtl/al422_bam_pkg.sv | 26 ++
 rtl/al422_fifo_bam_driver_if.sv | 41 ++++
 rtl/bam_display_timer.sv | 34 +++
 rtl/al422_fifo_bam_driver.sv | 195 +++++++++++++++++++
 tb/tb_al422_fifo_bam_driver.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/al422_bam_pkg.sv
// Shared types and constants for the AL422 FIFO to HUB75 BAM panel driver.
package al422_bam_pkg;

    localparam int unsigned COLUMNS_DEF    = 64;
    localparam int unsigned ROW_BITS_DEF   = 5;
    localparam int unsigned BAM_BITS_DEF   = 4;
    localparam int unsigned BASE_TICKS_DEF = 32;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned RGB_W    = 3;
    localparam int unsigned RGB1_LSB = 0;
    localparam int unsigned RGB2_LSB = 3;

    typedef enum logic [1:0] {
        FRST    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/al422_fifo_bam_driver_if.sv
// FIFO read port and panel connector signals between the driver and the board.
interface al422_fifo_bam_driver_if
    import al422_bam_pkg::*;
#(
    parameter int unsigned ROW_BITS = ROW_BITS_DEF
);
    logic [DATA_W-1:0]   in_data;
    logic                al422_re_out;
    logic                al422_nrst_out;
    logic                led_clk_out;
    logic                led_lat_out;
    logic                led_oe_out;
    logic [ROW_BITS-1:0] led_row;
    logic [RGB_W-1:0]    rgb1;
    logic [RGB_W-1:0]    rgb2;

    modport master (
        input  in_data,
        output al422_re_out,
        output al422_nrst_out,
        output led_clk_out,
        output led_lat_out,
        output led_oe_out,
        output led_row,
        output rgb1,
        output rgb2
    );

    modport slave (
        output in_data,
        input  al422_re_out,
        input  al422_nrst_out,
        input  led_clk_out,
        input  led_lat_out,
        input  led_oe_out,
        input  led_row,
        input  rgb1,
        input  rgb2
    );

endinterface

// File: rtl/bam_display_timer.sv
// Down-counter for one bitplane display period of BASE_TICKS<<plane cycles.
module bam_display_timer
    import al422_bam_pkg::*;
#(
    parameter  int unsigned BAM_BITS   = BAM_BITS_DEF,
    parameter  int unsigned BASE_TICKS = BASE_TICKS_DEF,
    localparam int unsigned PLANE_W    = idx_width(BAM_BITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    output logic               done_c
);

    localparam int unsigned MAX_TICKS = BASE_TICKS << (BAM_BITS - 1);
    localparam int unsigned TIMER_W   = $clog2(MAX_TICKS + 1);

    logic [TIMER_W-1:0] cnt;

    // Loaded the cycle before the period starts, so the final cycle sees cnt==1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TIMER_W'(BASE_TICKS << plane);
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    assign done_c = (cnt == TIMER_W'(1));

endmodule

// File: rtl/al422_fifo_bam_driver.sv
// Reads row-major/bitplane-inner bytes from an AL422 FIFO and scans them onto a
// 1/2**ROW_BITS HUB75 panel with binary angle modulation.
module al422_fifo_bam_driver
    import al422_bam_pkg::*;
#(
    parameter int unsigned COLUMNS    = COLUMNS_DEF,
    parameter int unsigned ROW_BITS   = ROW_BITS_DEF,
    parameter int unsigned BAM_BITS   = BAM_BITS_DEF,
    parameter int unsigned BASE_TICKS = BASE_TICKS_DEF
) (
    input  logic                    in_clk,
    input  logic                    in_nrst,
    al422_fifo_bam_driver_if.master bus
);

    localparam int unsigned COL_W   = idx_width(COLUMNS);
    localparam int unsigned PLANE_W = idx_width(BAM_BITS);

    localparam logic [COL_W-1:0]    LAST_COL   = COL_W'(COLUMNS - 1);
    localparam logic [PLANE_W-1:0]  LAST_PLANE = PLANE_W'(BAM_BITS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW   = ROW_BITS'((1 << ROW_BITS) - 1);

    state_t              state, state_d;
    logic                armed;
    logic [COL_W-1:0]    col, col_d;
    logic                phase, phase_d;
    logic [PLANE_W-1:0]  plane, plane_d;
    logic [ROW_BITS-1:0] row, row_d;

    logic re_d, fifo_nrst_d, led_clk_d, lat_d, oe_d;

    logic                re_q, fifo_nrst_q, led_clk_q, lat_q, oe_q;
    logic [ROW_BITS-1:0] led_row_q;
    logic [RGB_W-1:0]    rgb1_q, rgb2_q;

    logic timer_load_c, timer_done_c;

    logic [DATA_W-RGB2_LSB-RGB_W-1:0] unused_in_bits;
    assign unused_in_bits = bus.in_data[DATA_W-1:RGB2_LSB+RGB_W];

    assign timer_load_c = (state == LATCH);

    bam_display_timer #(
        .BAM_BITS   (BAM_BITS),
        .BASE_TICKS (BASE_TICKS)
    ) u_timer (
        .clk    (in_clk),
        .rst    (in_nrst),
        .load   (timer_load_c),
        .plane  (plane),
        .done_c (timer_done_c)
    );

    // State, counters and outputs; outputs are registered from the next state so
    // they always describe the state currently held.
    always_ff @(posedge in_clk) begin
        if (in_nrst) begin
            state       <= FRST;
            armed       <= 1'b0;
            col         <= '0;
            phase       <= 1'b0;
            plane       <= '0;
            row         <= '0;
            re_q        <= 1'b1;
            fifo_nrst_q <= 1'b1;
            led_clk_q   <= 1'b0;
            lat_q       <= 1'b0;
            oe_q        <= 1'b1;
            led_row_q   <= '0;
            rgb1_q      <= '0;
            rgb2_q      <= '0;
        end else begin
            state       <= state_d;
            armed       <= 1'b1;
            col         <= col_d;
            phase       <= phase_d;
            plane       <= plane_d;
            row         <= row_d;
            re_q        <= re_d;
            fifo_nrst_q <= fifo_nrst_d;
            led_clk_q   <= led_clk_d;
            lat_q       <= lat_d;
            oe_q        <= oe_d;
            if (state_d == LATCH) begin
                led_row_q <= row_d;
            end
            // The FIFO word is valid during the read phase and taken as it advances.
            if (state == SHIFT && !phase) begin
                rgb1_q <= bus.in_data[RGB1_LSB +: RGB_W];
                rgb2_q <= bus.in_data[RGB2_LSB +: RGB_W];
            end
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_d = state;
        col_d   = col;
        phase_d = phase;
        plane_d = plane;
        row_d   = row;

        if (!armed) begin
            state_d = FRST;
            col_d   = '0;
            phase_d = 1'b0;
            plane_d = '0;
            row_d   = '0;
        end else begin
            case (state)
                FRST: begin
                    state_d = SHIFT;
                    col_d   = '0;
                    phase_d = 1'b0;
                    plane_d = '0;
                    row_d   = '0;
                end
                SHIFT: begin
                    if (!phase) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col == LAST_COL) begin
                            col_d   = '0;
                            state_d = LATCH;
                        end else begin
                            col_d = col + COL_W'(1);
                        end
                    end
                end
                LATCH: begin
                    state_d = DISPLAY;
                end
                DISPLAY: begin
                    if (timer_done_c) begin
                        if (plane != LAST_PLANE) begin
                            plane_d = plane + PLANE_W'(1);
                            state_d = SHIFT;
                        end else if (row != LAST_ROW) begin
                            plane_d = '0;
                            row_d   = row + ROW_BITS'(1);
                            state_d = SHIFT;
                        end else begin
                            plane_d = '0;
                            row_d   = '0;
                            state_d = FRST;
                        end
                    end
                end
                default: begin
                    state_d = FRST;
                end
            endcase
        end
    end

    // Panel and FIFO strobes for the state being entered.
    always_comb begin
        re_d        = 1'b1;
        fifo_nrst_d = 1'b1;
        led_clk_d   = 1'b0;
        lat_d       = 1'b0;
        oe_d        = 1'b1;

        case (state_d)
            FRST: begin
                re_d        = 1'b0;
                fifo_nrst_d = 1'b0;
            end
            SHIFT: begin
                re_d      = phase_d;
                led_clk_d = phase_d;
            end
            LATCH: begin
                lat_d = 1'b1;
            end
            DISPLAY: begin
                oe_d = 1'b0;
            end
            default: begin
                re_d = 1'b1;
            end
        endcase
    end

    assign bus.al422_re_out   = re_q;
    assign bus.al422_nrst_out = fifo_nrst_q;
    assign bus.led_clk_out    = led_clk_q;
    assign bus.led_lat_out    = lat_q;
    assign bus.led_oe_out     = oe_q;
    assign bus.led_row        = led_row_q;
    assign bus.rgb1           = rgb1_q;
    assign bus.rgb2           = rgb2_q;

endmodule

// File: tb/tb_al422_fifo_bam_driver.sv
// Bench for al422_fifo_bam_driver: AL422 FIFO model, pixel scoreboard and timed vectors.
module tb_al422_fifo_bam_driver;
    import al422_bam_pkg::*;

    localparam int FRAME_WORDS = 8192;
    localparam int ROW_CYC     = 996;
    localparam int FRAME_CYC   = 31873;
    localparam int N_PLANES    = 128;

    typedef struct {
        int         t;
        logic [9:0] ctrl;
        logic       chk_rgb;
        logic [5:0] rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    al422_fifo_bam_driver_if #(.ROW_BITS(ROW_BITS_DEF)) bus ();

    al422_fifo_bam_driver dut (
        .in_clk  (clk),
        .in_nrst (rst),
        .bus     (bus)
    );

    logic [7:0]  mem [0:FRAME_WORDS-1];
    logic [13:0] addr = 14'd100;
    int          reads = 0;
    logic [5:0]  exp_q [$];

    assign bus.in_data = addr[13] ? 8'hFF : mem[addr[12:0]];

    // AL422 read port: pointer reset or advance on each enabled edge.
    always @(posedge clk) begin
        if (!bus.al422_re_out) begin
            if (!bus.al422_nrst_out) begin
                addr <= '0;
            end else begin
                addr <= addr + 14'd1;
                if (!rst) begin
                    exp_q.push_back(bus.in_data[5:0]);
                    reads <= reads + 1;
                end
            end
        end
    end

    int   checks = 0;
    int   passes = 0;
    int   t = 0;
    logic mon_on = 1'b0;
    logic prev_clk = 1'b0;
    logic [4:0] prev_row = '0;
    logic rose = 1'b0;
    int   oe_run = 0;
    int   clk_cnt = 0;
    int   oe_runs [$];
    int   clk_cnts [$];
    int   lat_rows [$];
    int   lat_times [$];
    vec_t vecs [$];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void add_vec(input int tt, input logic re, input logic nrst, input logic lclk,
                                    input logic lat, input logic oe, input logic [4:0] row,
                                    input logic ck, input logic [2:0] r1, input logic [2:0] r2);
        vec_t v;
        v.t       = tt;
        v.ctrl    = {re, nrst, lclk, lat, oe, row};
        v.chk_rgb = ck;
        v.rgb     = {r2, r1};
        vecs.push_back(v);
    endfunction

    function automatic logic [9:0] ctrl_now();
        return {bus.al422_re_out, bus.al422_nrst_out, bus.led_clk_out,
                bus.led_lat_out, bus.led_oe_out, bus.led_row};
    endfunction

    // Per-cycle monitor: blanking rules, pixel scoreboard, latch bookkeeping.
    task automatic sample();
        rose = 1'b0;
        if (!mon_on) return;
        chk("oe_low_while_busy",
            int'(!bus.led_oe_out && (bus.led_lat_out || !bus.al422_re_out || bus.led_clk_out)), 0);
        if (!bus.led_oe_out) begin
            oe_run++;
        end else if (oe_run != 0) begin
            oe_runs.push_back(oe_run);
            oe_run = 0;
        end
        if (bus.led_clk_out && !prev_clk) begin
            rose = 1'b1;
            clk_cnt++;
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else chk($sformatf("pixel@t%0d", t), int'({bus.rgb2, bus.rgb1}), int'(exp_q.pop_front()));
        end
        if (bus.led_lat_out) begin
            clk_cnts.push_back(clk_cnt);
            clk_cnt = 0;
            lat_rows.push_back(int'(bus.led_row));
            lat_times.push_back(t);
        end
        if (bus.led_row != prev_row) chk($sformatf("row_change_outside_latch@t%0d", t), int'(bus.led_lat_out), 1);
        prev_clk = bus.led_clk_out;
        prev_row = bus.led_row;
    endtask

    logic [2:0] post_rgb1 [4];
    logic       found;
    int         n_rise;

    initial begin
        for (int i = 0; i < FRAME_WORDS; i++) mem[i] = (i >= 64) ? 8'($urandom) : 8'h00;
        mem[0] = 8'h02;  mem[1] = 8'h02;  mem[2] = 8'h02;
        mem[21] = 8'h02; mem[22] = 8'h02; mem[23] = 8'h02;
        mem[27] = 8'h02; mem[28] = 8'h02; mem[29] = 8'h02;
        post_rgb1[0] = 3'd2; post_rgb1[1] = 3'd2; post_rgb1[2] = 3'd2; post_rgb1[3] = 3'd0;

        //       t      re nrst clk lat oe row  chk r1 r2
        add_vec(0,      0, 0,   0,  0,  1, 0,   1, 0, 0);
        add_vec(1,      0, 1,   0,  0,  1, 0,   1, 0, 0);
        add_vec(2,      1, 1,   1,  0,  1, 0,   1, 2, 0);
        add_vec(7,      0, 1,   0,  0,  1, 0,   1, 2, 0);
        add_vec(8,      1, 1,   1,  0,  1, 0,   1, 0, 0);
        add_vec(44,     1, 1,   1,  0,  1, 0,   1, 2, 0);
        add_vec(50,     1, 1,   1,  0,  1, 0,   1, 0, 0);
        add_vec(128,    1, 1,   1,  0,  1, 0,   1, 0, 0);
        add_vec(129,    1, 1,   0,  1,  1, 0,   1, 0, 0);
        add_vec(130,    1, 1,   0,  0,  0, 0,   1, 0, 0);
        add_vec(161,    1, 1,   0,  0,  0, 0,   1, 0, 0);
        add_vec(162,    0, 1,   0,  0,  1, 0,   1, 0, 0);
        add_vec(163,    1, 1,   1,  0,  1, 0,   0, 0, 0);
        add_vec(1124,   1, 1,   1,  0,  1, 0,   0, 0, 0);
        add_vec(1125,   1, 1,   0,  1,  1, 1,   0, 0, 0);
        add_vec(31872,  1, 1,   0,  0,  0, 31,  0, 0, 0);
        add_vec(31873,  0, 0,   0,  0,  1, 31,  0, 0, 0);
        add_vec(31874,  0, 1,   0,  0,  1, 31,  0, 0, 0);
        add_vec(31875,  1, 1,   1,  0,  1, 31,  1, 2, 0);

        // Reset held for two edges.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset_ctrl%0d", i), int'(ctrl_now()), int'(10'b11_0_0_1_00000));
            chk($sformatf("reset_rgb%0d", i), int'({bus.rgb2, bus.rgb1}), 0);
        end
        rst = 1'b0;
        mon_on = 1'b1;

        begin
            int vi = 0;
            for (int c = 0; c <= FRAME_CYC + 4; c++) begin
                @(negedge clk);
                t = c;
                sample();
                if (c == 1) chk("fifo_addr_after_frst", int'(addr), 0);
                if (c == FRAME_CYC) chk("frame_reads", reads, FRAME_WORDS);
                if (vi < vecs.size() && vecs[vi].t == c) begin
                    chk($sformatf("ctrl@t%0d", c), int'(ctrl_now()), int'(vecs[vi].ctrl));
                    if (vecs[vi].chk_rgb)
                        chk($sformatf("rgb@t%0d", c), int'({bus.rgb2, bus.rgb1}), int'(vecs[vi].rgb));
                    vi++;
                end
            end
            chk("vectors_applied", vi, vecs.size());
        end

        // Plane timing, shift counts and row order across the first frame.
        chk("oe_run_count", int'(oe_runs.size() >= N_PLANES), 1);
        chk("latch_count", int'(lat_times.size() >= N_PLANES), 1);
        if (oe_runs.size() >= N_PLANES && lat_times.size() >= N_PLANES) begin
            for (int i = 0; i < N_PLANES; i++) begin
                chk($sformatf("oe_len[%0d]", i), oe_runs[i], 32 << (i % 4));
                chk($sformatf("shift_clks[%0d]", i), clk_cnts[i], 64);
                chk($sformatf("latch_row[%0d]", i), lat_rows[i], i / 4);
                if (i + 4 < N_PLANES)
                    chk($sformatf("row_period[%0d]", i), lat_times[i + 4] - lat_times[i], ROW_CYC);
            end
            chk("first_latch_t", lat_times[0], 129);
        end

        // Mid-frame reset during row 5 display of the second frame.
        found = 1'b0;
        for (int c = 0; c < 8000 && !found; c++) begin
            @(negedge clk);
            t++;
            sample();
            if (bus.led_row == 5'd5 && !bus.led_oe_out) found = 1'b1;
        end
        chk("row5_display_reached", int'(found), 1);
        rst = 1'b1;
        mon_on = 1'b0;
        @(negedge clk);
        chk("midreset_ctrl", int'(ctrl_now()), int'(10'b11_0_0_1_00000));
        chk("midreset_rgb", int'({bus.rgb2, bus.rgb1}), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("restart_frst", int'(ctrl_now()), int'(10'b00_0_0_1_00000));
        prev_clk = bus.led_clk_out;
        prev_row = bus.led_row;
        mon_on = 1'b1;
        n_rise = 0;
        for (int c = 0; c < 300 && n_rise < 4; c++) begin
            @(negedge clk);
            t++;
            sample();
            if (rose) begin
                chk($sformatf("restart_pix%0d", n_rise), int'(bus.rgb1), int'(post_rgb1[n_rise]));
                n_rise++;
            end
        end
        chk("restart_edges", n_rise, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
